// File: rtl/wb_line_ram.sv
// wb_line_ram: Wishbone classic line-wide RAM with per-word select and LATENCY wait states.
// Define WB_LINE_RAM_BOUNDS_CHECK_EN to answer out-of-range accesses with err instead of aliasing.
module wb_line_ram #(
  parameter int          DATA_WIDTH  = 128,
  parameter int          GRANULARITY = 32,
  parameter int          DEPTH_LOG2  = 10,
  parameter int          LATENCY     = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [31:0]                         wb_adr_i,
  input  logic [DATA_WIDTH-1:0]               wb_dat_i,
  output logic [DATA_WIDTH-1:0]               wb_dat_o,
  input  logic                                wb_we_i,
  input  logic [DATA_WIDTH/GRANULARITY-1:0]   wb_sel_i,
  input  logic                                wb_stb_i,
  input  logic                                wb_cyc_i,
  output logic                                wb_ack_o,
  output logic                                wb_err_o,
  output logic                                wb_rty_o
);
  localparam int SEL_WIDTH = DATA_WIDTH / GRANULARITY;
  localparam int SEL_LOG2  = $clog2(SEL_WIDTH);
  localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
  if (LATENCY < 0 || LATENCY > 15) begin : g_latency_check
    $error("wb_line_ram: LATENCY must be within 0..15");
  end
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [1:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic we_q, we_d, ok_q, ok_d, ack_q, ack_d, err_q, err_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] wdat_q, wdat_d, rdat_q, rdat_d;
  logic [32:0] diff;
  logic in_range, unused;
  assign diff = {1'b0, wb_adr_i} - {1'b0, BASE_ADDR};
`ifdef WB_LINE_RAM_BOUNDS_CHECK_EN
  localparam logic [32:0] LIMIT = 33'(SEL_WIDTH) << DEPTH_LOG2;
  // diff[32] is the borrow, set when the address lies below BASE_ADDR
  assign in_range = !diff[32] && diff < LIMIT;
`else
  assign in_range = 1'b1;
`endif
  assign unused = ^diff;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ok_d    = ok_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    wdat_d  = wdat_q;
    ack_d   = state_q == RESP && ok_q;
    err_d   = state_q == RESP && !ok_q;
    rdat_d  = (state_q == RESP && !we_q && ok_q) ? mem[idx_q] : rdat_q;
    if (state_q == IDLE) begin
      if (wb_cyc_i && wb_stb_i) begin
        state_d = LATENCY == 0 ? RESP : WAIT;
        cnt_d   = 4'(LATENCY);
        we_d    = wb_we_i;
        ok_d    = in_range;
        sel_d   = wb_sel_i;
        idx_d   = diff[SEL_LOG2 +: DEPTH_LOG2];
        wdat_d  = wb_dat_i;
      end
    end else if (state_q == WAIT) begin
      state_d = !wb_cyc_i ? IDLE : cnt_q == 4'd1 ? RESP : WAIT;
      cnt_d   = cnt_q - 4'd1;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ok_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ok_q    <= ok_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
    end
  end
  // reset pulls state_q out of RESP at once, so an in-flight write never lands
  always_ff @(posedge clk) begin
    if (state_q == RESP && we_q && ok_q)
      for (int k = 0; k < SEL_WIDTH; k++)
        if (sel_q[k]) mem[idx_q][k*GRANULARITY +: GRANULARITY] <= wdat_q[k*GRANULARITY +: GRANULARITY];
  end
  assign wb_dat_o = rdat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign wb_rty_o = 1'b0;
endmodule
